// File: rtl/modmul_issue_pkg.sv
// ============================================================================
// modmul_issue_pkg : shared constants, types and issue-state enum
// Rev 1.0
// ============================================================================
`default_nettype none

package modmul_issue_pkg;

    localparam int WORDSZ   = 256;
    localparam int RFSZLOG2 = 5;
    localparam int LAT      = 34;
    localparam int NREG     = 1 << RFSZLOG2;
    localparam int CNTW     = $clog2(LAT + 1);

    typedef logic [RFSZLOG2-1:0] reg_addr_t;
    typedef logic [WORDSZ-1:0]   word_t;
    typedef logic [CNTW-1:0]     cnt_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/modmul_scoreboard.sv
// ============================================================================
// modmul_scoreboard : pending-destination vector, in-flight count, drop timer
// Rev 1.0
// ============================================================================
`default_nettype none

module modmul_scoreboard
    import modmul_issue_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [RFSZLOG2-1:0] set_addr,
    input  logic                clr_en,
    input  logic [RFSZLOG2-1:0] clr_addr,
    input  logic [RFSZLOG2-1:0] look_src1,
    input  logic [RFSZLOG2-1:0] look_src2,
    input  logic [RFSZLOG2-1:0] look_dst,
    output logic                hit_src1,
    output logic                hit_src2,
    output logic                hit_dst,
    output logic [CNTW-1:0]     count,
    output logic                busy,
    output logic                drop_active
);

    logic [NREG-1:0] r_pending;
    cnt_t            r_count;
    cnt_t            r_drop;
    logic            w_inc;
    logic            w_dec;

    // Register 0 is the no-op tag, so its bit can never be set.
    assign w_inc = set_en && (set_addr != '0);
    // Clearing a non-pending tag is a protocol error and must not move the count.
    assign w_dec = clr_en && r_pending[clr_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_count   <= '0;
            r_drop    <= cnt_t'(LAT);
        end else begin
            if (r_drop != '0) begin
                r_drop <= r_drop - cnt_t'(1);
            end
            if (clr_en) begin
                r_pending[clr_addr] <= 1'b0;
            end
            if (w_inc) begin
                r_pending[set_addr] <= 1'b1;
            end
            r_count <= r_count + cnt_t'(w_inc) - cnt_t'(w_dec);
        end
    end

    assign hit_src1    = r_pending[look_src1];
    assign hit_src2    = r_pending[look_src2];
    assign hit_dst     = r_pending[look_dst];
    assign count       = r_count;
    assign busy        = (r_count != '0);
    assign drop_active = (r_drop != '0);

endmodule

`default_nettype wire

// File: rtl/modmul_issue.sv
// ============================================================================
// modmul_issue : issue/writeback controller for the pipelined Montgomery modmul
// Optional writeback forwarding: define MODMUL_ISSUE_WB_BYPASS_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module modmul_issue
    import modmul_issue_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RFSZLOG2-1:0] in_dst,
    input  logic [RFSZLOG2-1:0] in_src1,
    input  logic [RFSZLOG2-1:0] in_src2,
    output logic [RFSZLOG2-1:0] rf_raddr1,
    output logic [RFSZLOG2-1:0] rf_raddr2,
    input  logic [WORDSZ-1:0]   rf_rdata1,
    input  logic [WORDSZ-1:0]   rf_rdata2,
    output logic                mm_en,
    output logic [WORDSZ-1:0]   mm_a,
    output logic [WORDSZ-1:0]   mm_b,
    output logic [RFSZLOG2-1:0] mm_rn,
    input  logic [WORDSZ-1:0]   mm_res,
    input  logic [RFSZLOG2-1:0] mm_rn_out,
    output logic                wb_en,
    output logic [RFSZLOG2-1:0] wb_addr,
    output logic [WORDSZ-1:0]   wb_data,
    input  logic                flush,
    output logic                flush_done,
    output logic                busy,
    output logic                err
);

    issue_state_t r_state;
    logic         r_err;
    logic         r_wb_en;
    reg_addr_t    r_wb_addr;
    word_t        r_wb_data;

    logic         w_hit_src1;
    logic         w_hit_src2;
    logic         w_hit_dst;
    cnt_t         w_count;
    logic         w_busy;
    logic         w_drop_active;
    logic         w_fwd1;
    logic         w_fwd2;
    logic         w_hazard;
    logic         w_accept;
    logic         w_issue;
    logic         w_drained;

`ifdef MODMUL_ISSUE_WB_BYPASS_EN
    // The writeback commits at this edge, so its data is the newest value of that register.
    assign w_fwd1 = r_wb_en && (r_wb_addr == in_src1);
    assign w_fwd2 = r_wb_en && (r_wb_addr == in_src2);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    assign w_hazard  = (w_hit_src1 && !w_fwd1) || (w_hit_src2 && !w_fwd2) || w_hit_dst;
    assign in_ready  = !rst && (r_state == RUN) && !flush && !w_hazard && (w_count < cnt_t'(LAT));
    assign w_accept  = in_valid && in_ready;
    assign w_issue   = w_accept && (in_dst != '0);
    assign w_drained = (w_count == '0) && !r_wb_en;

    assign rf_raddr1 = in_src1;
    assign rf_raddr2 = in_src2;

    assign mm_en = w_issue;
    assign mm_rn = w_issue ? in_dst : '0;
    assign mm_a  = !w_issue ? '0 : (w_fwd1 ? r_wb_data : rf_rdata1);
    assign mm_b  = !w_issue ? '0 : (w_fwd2 ? r_wb_data : rf_rdata2);

    modmul_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (w_issue),
        .set_addr    (in_dst),
        .clr_en      (r_wb_en),
        .clr_addr    (r_wb_addr),
        .look_src1   (in_src1),
        .look_src2   (in_src2),
        .look_dst    (in_dst),
        .hit_src1    (w_hit_src1),
        .hit_src2    (w_hit_src2),
        .hit_dst     (w_hit_dst),
        .count       (w_count),
        .busy        (w_busy),
        .drop_active (w_drop_active)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                RUN:     if (flush) r_state <= DRAIN;
                DRAIN:   if (w_drained) r_state <= RUN;
                default: r_state <= RUN;
            endcase
            if (w_accept && (in_dst == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Results tagged before a reset are still in the pipe; the drop timer discards them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_en   <= (mm_rn_out != '0) && !w_drop_active;
            r_wb_addr <= mm_rn_out;
            r_wb_data <= mm_res;
        end
    end

    assign wb_en      = r_wb_en;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign flush_done = !rst && (r_state == DRAIN) && w_drained;
    assign busy       = w_busy;
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_modmul_issue.sv
// ============================================================================
// tb_modmul_issue : directed bench with register-file model, modmul delay line
// and an expected-writeback queue. Rev 1.0
// ============================================================================
`default_nettype none

module tb_modmul_issue;
    import modmul_issue_pkg::*;

`ifdef MODMUL_ISSUE_WB_BYPASS_EN
    localparam int RAW_LAT = LAT + 1;
`else
    localparam int RAW_LAT = LAT + 2;
`endif

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [RFSZLOG2-1:0] in_dst;
    logic [RFSZLOG2-1:0] in_src1;
    logic [RFSZLOG2-1:0] in_src2;
    logic [RFSZLOG2-1:0] rf_raddr1;
    logic [RFSZLOG2-1:0] rf_raddr2;
    logic [WORDSZ-1:0]   rf_rdata1;
    logic [WORDSZ-1:0]   rf_rdata2;
    logic                mm_en;
    logic [WORDSZ-1:0]   mm_a;
    logic [WORDSZ-1:0]   mm_b;
    logic [RFSZLOG2-1:0] mm_rn;
    logic [WORDSZ-1:0]   mm_res;
    logic [RFSZLOG2-1:0] mm_rn_out;
    logic                wb_en;
    logic [RFSZLOG2-1:0] wb_addr;
    logic [WORDSZ-1:0]   wb_data;
    logic                flush;
    logic                flush_done;
    logic                busy;
    logic                err;

    modmul_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dst     (in_dst),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .mm_en      (mm_en),
        .mm_a       (mm_a),
        .mm_b       (mm_b),
        .mm_rn      (mm_rn),
        .mm_res     (mm_res),
        .mm_rn_out  (mm_rn_out),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .flush_done (flush_done),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file written by the DUT writeback and by the bench preload port.
    logic [WORDSZ-1:0]   rf [NREG] = '{default: '0};
    logic                tb_we;
    logic [RFSZLOG2-1:0] tb_waddr;
    logic [WORDSZ-1:0]   tb_wdata;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always @(posedge clk) begin
        if (wb_en) rf[wb_addr] <= wb_data;
        if (tb_we) rf[tb_waddr] <= tb_wdata;
    end

    // Modmul stand-in: fixed LAT-cycle delay, result = a*b + 0x88. Not reset on purpose.
    logic [RFSZLOG2-1:0] p_rn  [LAT] = '{default: '0};
    logic [WORDSZ-1:0]   p_res [LAT] = '{default: '0};

    always @(posedge clk) begin
        p_rn[0]  <= mm_en ? mm_rn : '0;
        p_res[0] <= mm_a * mm_b + 256'h88;
        for (int i = 1; i < LAT; i++) begin
            p_rn[i]  <= p_rn[i-1];
            p_res[i] <= p_res[i-1];
        end
    end

    assign mm_rn_out = p_rn[LAT-1];
    assign mm_res    = p_res[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    logic [WORDSZ-1:0]          ref_rf [NREG] = '{default: '0};
    logic [RFSZLOG2+WORDSZ-1:0] exp_q [$];

    task automatic check(input string tag, input logic [WORDSZ-1:0] obs, input logic [WORDSZ-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [RFSZLOG2-1:0] d, input logic [RFSZLOG2-1:0] s1,
                         input logic [RFSZLOG2-1:0] s2);
        in_valid = 1'b1;
        in_dst   = d;
        in_src1  = s1;
        in_src2  = s2;
    endtask

    task automatic push_exp(input logic [RFSZLOG2-1:0] d, input logic [RFSZLOG2-1:0] s1,
                            input logic [RFSZLOG2-1:0] s2);
        logic [WORDSZ-1:0] v;
        v = ref_rf[s1] * ref_rf[s2] + 256'h88;
        ref_rf[d] = v;
        exp_q.push_back({d, v});
    endtask

    task automatic rf_load(input logic [RFSZLOG2-1:0] a, input logic [WORDSZ-1:0] d);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        ref_rf[a] = d;
        step();
        tb_we = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        check("idle_timeout", 256'(k < 200), 256'(1));
    endtask

    // Writeback scoreboard: each writeback must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && wb_en) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL wb_spurious: observed writeback to %0d expected none", wb_addr);
            end
            if (exp_q.size() != 0) begin
                logic [RFSZLOG2+WORDSZ-1:0] e;
                e = exp_q.pop_front();
                check("wb_addr", 256'(wb_addr), 256'(e[RFSZLOG2+WORDSZ-1:WORDSZ]));
                check("wb_data", wb_data, e[WORDSZ-1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int k;
        rst = 1'b1; in_valid = 1'b0; in_dst = '0; in_src1 = '0; in_src2 = '0;
        flush = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        step();
        step();
        rf_load(1, 5);
        rf_load(2, 7);
        rf_load(5, 9);
        rf_load(6, 3);
        rf_load(7, 11);
        rf_load(8, 2);

        // Reset state, with a valid instruction presented
        drive(3, 1, 2);
        #1;
        check("rst_in_ready",   256'(in_ready),   256'(0));
        check("rst_mm_en",      256'(mm_en),      256'(0));
        check("rst_wb_en",      256'(wb_en),      256'(0));
        check("rst_flush_done", 256'(flush_done), 256'(0));
        check("rst_busy",       256'(busy),       256'(0));
        check("rst_err",        256'(err),        256'(0));
        in_valid = 1'b0;
        step();
        rst = 1'b0;

        // Single op
        drive(3, 1, 2);
        #1;
        check("single_ready", 256'(in_ready), 256'(1));
        check("single_mm_en", 256'(mm_en),    256'(1));
        check("single_mm_rn", 256'(mm_rn),    256'(3));
        check("single_mm_a",  mm_a,           256'(5));
        check("single_mm_b",  mm_b,           256'(7));
        push_exp(3, 1, 2);
        t0 = cyc;
        step();
        in_valid = 1'b0;
        #1;
        check("single_busy", 256'(busy), 256'(1));
        check("single_idle_mm_a", mm_a, 256'(0));
        k = 0;
        while (!wb_en && k < 100) begin step(); k++; end
        check("single_wb_cycle", 256'(cyc - t0), 256'(LAT + 1));
        check("single_busy_wb",  256'(busy), 256'(1));
        step();
        check("single_busy_after", 256'(busy), 256'(0));

        // RAW hazard
        wait_idle();
        drive(3, 6, 7);
        #1;
        check("raw_first_ready", 256'(in_ready), 256'(1));
        push_exp(3, 6, 7);
        t0 = cyc;
        step();
        drive(9, 3, 8);
        #1;
        k = 0;
        while (!in_ready && k < 100) begin step(); #1; k++; end
        check("raw_issue_cycle", 256'(cyc - t0), 256'(RAW_LAT));
        check("raw_mm_a", mm_a, ref_rf[3]);
        push_exp(9, 3, 8);
        step();
        in_valid = 1'b0;

        // WAW hazard
        wait_idle();
        drive(4, 1, 2);
        #1;
        push_exp(4, 1, 2);
        t0 = cyc;
        step();
        drive(4, 6, 8);
        #1;
        k = 0;
        while (!in_ready && k < 100) begin step(); #1; k++; end
        check("waw_issue_cycle", 256'(cyc - t0), 256'(LAT + 2));
        push_exp(4, 6, 8);
        step();
        in_valid = 1'b0;
        wait_idle();

        // Illegal destination
        drive(0, 1, 2);
        #1;
        check("illegal_ready", 256'(in_ready), 256'(1));
        check("illegal_mm_en", 256'(mm_en),    256'(0));
        check("illegal_mm_rn", 256'(mm_rn),    256'(0));
        step();
        in_valid = 1'b0;
        #1;
        check("illegal_err", 256'(err), 256'(1));
        repeat (3) step();
        check("illegal_err_held", 256'(err),  256'(1));
        check("illegal_busy",     256'(busy), 256'(0));

        // Flush with two ops in flight
        drive(10, 1, 2);
        #1;
        push_exp(10, 1, 2);
        t0 = cyc;
        step();
        drive(11, 6, 7);
        #1;
        check("flush_second_ready", 256'(in_ready), 256'(1));
        push_exp(11, 6, 7);
        step();
        drive(12, 1, 2);
        flush = 1'b1;
        #1;
        check("flush_cycle_ready", 256'(in_ready), 256'(0));
        check("flush_cycle_mm_en", 256'(mm_en),    256'(0));
        step();
        flush = 1'b0;
        #1;
        check("drain_ready", 256'(in_ready), 256'(0));
        k = 0;
        while (!flush_done && k < 100) begin step(); #1; k++; end
        check("flush_done_cycle", 256'(cyc - t0), 256'(LAT + 3));
        step();
        #1;
        check("flush_done_pulse", 256'(flush_done), 256'(0));
        check("flush_ready_back", 256'(in_ready),   256'(1));
        push_exp(12, 1, 2);
        step();
        in_valid = 1'b0;
        wait_idle();

        // Reset mid-flight: the stale dst=5 result must be dropped
        drive(5, 1, 2);
        #1;
        check("midrst_issue", 256'(mm_en), 256'(1));
        step();
        in_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_err",  256'(err),  256'(0));
        drive(13, 5, 2);
        #1;
        check("midrst_src5_ready", 256'(in_ready), 256'(1));
        push_exp(13, 5, 2);
        step();
        in_valid = 1'b0;
        wait_idle();
        repeat (3) step();
        check("final_queue_empty", 256'(exp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/modmul_issue.md
Name: modmul_issue

Overview:
- Issue and writeback controller on the far side of the pipelined Montgomery modmul unit.
- Accepts modmul instructions (dst, src1, src2) through a valid/ready handshake and reads operands from the register file.
- Tracks in-flight destinations in a scoreboard, blocking RAW/WAW hazards, and drives the modmul en/a0/b0/rn0 inputs.
- Catches the tagged result (rn, res) after the fixed pipeline latency and writes it back to the register file.

Parameters:
- WORDSZ, 256, operand/result width.
- RFSZLOG2, 5, register-address width. Address 0 is the modmul "no-op" tag and is never a legal destination.
- LAT, 34, modmul latency from en/rn0 sampled to rn/res valid.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  instruction accepted this cycle when in_valid is also high.
- in_dst  in  RFSZLOG2  destination register.
- in_src1  in  RFSZLOG2  operand A register.
- in_src2  in  RFSZLOG2  operand B register.
- rf_raddr1  out  RFSZLOG2  register-file read address A; equals in_src1.
- rf_raddr2  out  RFSZLOG2  register-file read address B; equals in_src2.
- rf_rdata1  in  WORDSZ  combinational read data A.
- rf_rdata2  in  WORDSZ  combinational read data B.
- mm_en  out  1  modmul enable.
- mm_a  out  WORDSZ  modmul a0.
- mm_b  out  WORDSZ  modmul b0.
- mm_rn  out  RFSZLOG2  modmul rn0 tag.
- mm_res  in  WORDSZ  modmul result.
- mm_rn_out  in  RFSZLOG2  modmul result tag; 0 means no result.
- wb_en  out  1  register-file write enable.
- wb_addr  out  RFSZLOG2  write address.
- wb_data  out  WORDSZ  write data.
- flush  in  1  request drain.
- flush_done  out  1  one-cycle pulse when drained.
- busy  out  1  in-flight count nonzero.
- err  out  1  sticky illegal-destination flag.

Behaviour:
- Reset (while rst=1):
  - in_ready=0, mm_en=0, wb_en=0, flush_done=0, busy=0, err=0.
  - Scoreboard cleared, in-flight count set to 0, state = RUN.
  - Mid-operation reset drops all tracking.
  - A drop counter is loaded with LAT. While it is nonzero it decrements each cycle and any mm_rn_out!=0 is ignored (no wb_en), so stale results from pre-reset ops are discarded.
- Pending vector:
  - One bit per register; bit 0 is always 0.
  - Hazard = pending[in_src1] | pending[in_src2] | pending[in_dst].
- States:
  - RUN:
    - in_ready = !hazard && count<LAT.
    - Accept = in_valid && in_ready.
  - DRAIN:
    - Entered from RUN when flush=1. Flush takes priority over an accept in the same cycle, so no accept that cycle.
    - in_ready=0.
    - When count==0 and no wb_en is pending: pulse flush_done for 1 cycle, then return to RUN.
    - flush is ignored while in DRAIN.
- Issue (accept, in_dst!=0):
  - mm_en=1, mm_a=rf_rdata1, mm_b=rf_rdata2, mm_rn=in_dst, all in the same cycle (combinational).
  - pending[in_dst] set at the clock edge; count+1.
- Issue with in_dst==0:
  - The instruction is accepted and discarded: mm_en=0, err set sticky until rst.
- When mm_en=0: mm_a, mm_b and mm_rn are driven 0.
- Result capture:
  - When mm_rn_out!=0 and the drop counter is 0, register wb_en=1, wb_addr=mm_rn_out, wb_data=mm_res.
  - wb_en is therefore 1 cycle after the result appears, i.e. LAT+1 cycles after issue.
  - In the wb_en cycle, pending[wb_addr] clears and count-1, both at the edge. The register-file write commits at the same edge.
  - Earliest dependent issue: the cycle after wb_en.
- Simultaneous issue and writeback: the count update is +1-1 = unchanged. The issued dst can never equal wb_addr, because a pending dst blocks issue.
- mm_rn_out equal to an address whose pending bit is not set is a protocol error: still written back, the pending clear has no effect, and the count is not decremented below 0.
- busy = (count!=0).

Optional Feature:
- Macro: MODMUL_ISSUE_WB_BYPASS_EN.
- Defined:
  - A source that matches wb_addr while wb_en=1 is not a hazard.
  - The corresponding mm_a/mm_b takes wb_data instead of rf_rdata.
  - A dependent op can issue in the wb_en cycle, one cycle earlier.
  - A dst matching wb_addr still stalls for that cycle.
- Undefined: no forwarding; behaviour as above.

Decomposition:
- Shared package holds:
  - WORDSZ, RFSZLOG2 and LAT constants.
  - typedef reg_addr_t (logic [RFSZLOG2-1:0]).
  - typedef word_t.
  - Issue-state enum {RUN, DRAIN}.
- One sub-module, modmul_scoreboard, owns:
  - The pending vector.
  - The in-flight count.
  - Set/clear ports, the three hazard lookups, busy, and the drop counter.
- The top level owns the handshake, the FSM, and the operand and writeback muxing.

Test Plan:
- Single op: rf[1]=5, rf[2]=7, issue dst=3 at cycle 0 (mm_en=1, mm_rn=3), bench modmul returns res=0xAB with rn=3 at cycle 34 -> wb_en=1, wb_addr=3, wb_data=0xAB at cycle 35; busy 1 for cycles 1..35.
- RAW: op dst=3, then op src1=3 on the next cycle -> in_ready=0 until cycle 36 (cycle 35 with bypass, mm_a=wb_data).
- WAW: two ops both dst=4 back to back -> second accepted only after the first writes back; wb order 4 then 4.
- Illegal destination: in_dst=0, in_valid=1 -> in_ready=1, mm_en stays 0, err=1 the next cycle and held.
- Flush: 2 ops in flight, flush=1 -> in_ready=0, flush_done pulses the cycle after the second wb_en, then in_ready returns to 1.
- Reset mid-flight: assert rst 10 cycles after issuing dst=5; bench returns rn=5 at cycle 34 -> no wb_en, pending[5]=0, busy=0.
